serial_tx: RTL and testbench

- Serial transmitter paired with the team's serial receiver; shifts a latched word out on one line, MSB first.
- All timing is counted against a shared external `cnt` timebase, so both ends agree on bit boundaries.
- Sits between a control/register block, which supplies word, length and timing and pulses `start`, and the output pin or line driver.
- When `start` is issued at cnt==0, bit edges land on cnt = n0 + k·n1, which is exactly where the receiver samples.

---
 rtl/serial_tx.sv | 139 +++++++++++++
 tb/tb_serial_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// serial_tx: MSB-first serial transmitter timed against a shared free-running
// cnt timebase. Bit edges land on cnt == acceptance + n0 + k*n1 (mod 2^32),
// which matches the sampling points of the companion receiver.
// Optional even-parity bit after the data bits: define SERIAL_TX_PARITY_EN.
module serial_tx #(
    parameter bit P_Y_INIT    = 1'b0,
    parameter int P_NBITS_MAX = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [P_NBITS_MAX-1:0] data,
    input  logic [7:0]             nbits,
    input  logic [31:0]            n0,
    input  logic [31:0]            n1,
    input  logic [31:0]            cnt,
    output logic                   y,
    output logic                   busy,
    output logic                   done
);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, S0, S1, S2} state_t;
`else
    typedef enum logic [1:0] {IDLE, S0, S1} state_t;
`endif

    state_t                 state;
    logic [P_NBITS_MAX-1:0] data_l;
    logic [7:0]             nb_l;
    logic [31:0]            n1_l;
    logic [31:0]            t;
    logic [7:0]             idx;
`ifdef SERIAL_TX_PARITY_EN
    logic                   par;
`endif

    logic [31:0] i_n0;
    logic [31:0] i_n1;
    logic [7:0]  i_nb;
    logic [7:0]  nb_m1;
    logic [7:0]  idx_m1;
    logic        hit;

    // Zero-valued timing/length inputs are treated as 1; index helpers.
    always_comb begin
        i_n0   = (n0 == 32'd0) ? 32'd1 : n0;
        i_n1   = (n1 == 32'd0) ? 32'd1 : n1;
        i_nb   = (nbits == 8'd0) ? 8'd1 : nbits;
        nb_m1  = nb_l - 8'd1;
        idx_m1 = idx - 8'd1;
        hit    = (cnt == t);
    end

    // Frame sequencer: lead-in, data bits (and parity), return to idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            y      <= P_Y_INIT;
            busy   <= 1'b0;
            done   <= 1'b0;
            idx    <= '0;
            t      <= '0;
            data_l <= '0;
            nb_l   <= 8'd1;
            n1_l   <= 32'd1;
`ifdef SERIAL_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    y    <= P_Y_INIT;
                    if (start) begin
                        data_l <= data;
                        nb_l   <= i_nb;
                        n1_l   <= i_n1;
                        t      <= cnt + i_n0;
                        busy   <= 1'b1;
                        state  <= S0;
                    end
                end
                S0: begin
                    y <= P_Y_INIT;
                    if (hit) begin
                        y     <= data_l[nb_m1];
                        idx   <= nb_m1;
                        t     <= t + n1_l;
                        state <= S1;
`ifdef SERIAL_TX_PARITY_EN
                        par   <= data_l[nb_m1];
`endif
                    end
                end
                S1: begin
                    if (hit) begin
                        if (idx != 8'd0) begin
                            y   <= data_l[idx_m1];
                            idx <= idx_m1;
                            t   <= t + n1_l;
`ifdef SERIAL_TX_PARITY_EN
                            par <= par ^ data_l[idx_m1];
`endif
                        end else begin
`ifdef SERIAL_TX_PARITY_EN
                            y     <= par;
                            t     <= t + n1_l;
                            state <= S2;
`else
                            y     <= P_Y_INIT;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
`endif
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                S2: begin
                    if (hit) begin
                        y     <= P_Y_INIT;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    y     <= P_Y_INIT;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed bench for serial_tx. Expected line transitions and
// done pulses are pushed to queues when a frame is launched and popped as the
// DUT produces them; cnt is driven by the bench and steps once per clk.
module tb_serial_tx;

    typedef struct {
        logic [31:0] c;
        logic        v;
    } edge_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start0;
    logic         start1;
    logic [255:0] data;
    logic [7:0]   nbits;
    logic [31:0]  n0;
    logic [31:0]  n1;
    logic [31:0]  cnt;
    logic         y0, busy0, done0;
    logic         y1, busy1, done1;

    edge_t        edge_q[$];
    logic [31:0]  done_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic         prev_y;
    logic [31:0]  e;

    always #5 clk = ~clk;

    serial_tx #(.P_Y_INIT(1'b0), .P_NBITS_MAX(256)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .data(data), .nbits(nbits),
        .n0(n0), .n1(n1), .cnt(cnt), .y(y0), .busy(busy0), .done(done0)
    );

    serial_tx #(.P_Y_INIT(1'b1), .P_NBITS_MAX(256)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data(data), .nbits(nbits),
        .n0(n0), .n1(n1), .cnt(cnt), .y(y1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: sample outputs 1 time unit after the edge, score them, then step cnt.
    task automatic tick();
        edge_t x;
        @(posedge clk);
        #1;
        e = cnt;
        if (y0 !== prev_y) begin
            if (edge_q.size() == 0) begin
                chk("y_unexpected", {63'd0, y0}, {63'd0, prev_y});
            end else begin
                x = edge_q.pop_front();
                chk("edge_cnt", {32'd0, e}, {32'd0, x.c});
                chk("edge_val", {63'd0, y0}, {63'd0, x.v});
            end
            prev_y = y0;
        end
        if (done0 === 1'b1) begin
            if (done_q.size() == 0) chk("done_unexpected", {63'd0, done0}, 64'd0);
            else chk("done_cnt", {32'd0, e}, {32'd0, done_q.pop_front()});
        end
        cnt = cnt + 32'd1;
    endtask

    // Reference model of one frame on the P_Y_INIT=0 instance.
    task automatic push_frame(input logic [31:0] acc, input logic [255:0] d,
                              input logic [7:0] nb, input logic [31:0] a0,
                              input logic [31:0] a1);
        logic [31:0] t, i0, i1;
        int          inb;
        logic        b, pv, p;
        edge_t       x;
        i0  = (a0 == 32'd0) ? 32'd1 : a0;
        i1  = (a1 == 32'd0) ? 32'd1 : a1;
        inb = (nb == 8'd0) ? 1 : int'(nb);
        t   = acc + i0;
        pv  = 1'b0;
        p   = 1'b0;
        for (int k = inb - 1; k >= 0; k--) begin
            b = d[k];
            p = p ^ b;
            if (b !== pv) begin
                x.c = t; x.v = b; edge_q.push_back(x); pv = b;
            end
            t = t + i1;
        end
`ifdef SERIAL_TX_PARITY_EN
        if (p !== pv) begin
            x.c = t; x.v = p; edge_q.push_back(x); pv = p;
        end
        t = t + i1;
`endif
        if (pv !== 1'b0) begin
            x.c = t; x.v = 1'b0; edge_q.push_back(x);
        end
        done_q.push_back(t);
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while ((edge_q.size() != 0 || done_q.size() != 0) && n < maxc) begin
            tick();
            n++;
        end
        chk("drain_outstanding", 64'(edge_q.size() + done_q.size()), 64'd0);
        repeat (4) tick();
    endtask

    task automatic launch(input logic [255:0] d, input logic [7:0] nb,
                          input logic [31:0] a0, input logic [31:0] a1);
        data   = d;
        nbits  = nb;
        n0     = a0;
        n1     = a1;
        start0 = 1'b1;
        push_frame(cnt, d, nb, a0, a1);
        tick();
        start0 = 1'b0;
    endtask

    initial begin
        int n;
        logic [255:0] big;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        data = '0; nbits = 8'd4; n0 = 32'd3; n1 = 32'd2; cnt = 32'd0;
        prev_y = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_y0", {63'd0, y0}, 64'd0);
        chk("rst_busy0", {63'd0, busy0}, 64'd0);
        chk("rst_done0", {63'd0, done0}, 64'd0);
        chk("rst_y1", {63'd0, y1}, 64'd1);
        chk("rst_busy1", {63'd0, busy1}, 64'd0);
        rst = 1'b0;

        // Scenario 1: 1010, n0=3, n1=2, start at cnt=10
        while (cnt != 32'd10) tick();
        launch(256'hA, 8'd4, 32'd3, 32'd2);
        chk("s1_busy_accept", {63'd0, busy0}, 64'd1);
        repeat (12) begin
            tick();
            chk("s1_busy", {63'd0, busy0}, {63'd0, (e < 32'd21)});
        end
        wait_drain(10);

        // Scenario 2: clamped zeros on the idle-high instance
        cnt = 32'd5;
        data = 256'h1; nbits = 8'd0; n0 = 32'd0; n1 = 32'd0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("s2_busy_acc", {63'd0, busy1}, 64'd1);
        tick();
        chk("s2_y_bit", {63'd0, y1}, 64'd1);
        chk("s2_done_early", {63'd0, done1}, 64'd0);
        tick();
        chk("s2_y_idle", {63'd0, y1}, 64'd1);
        chk("s2_busy_end", {63'd0, busy1}, 64'd0);
        chk("s2_done", {63'd0, done1}, 64'd1);
        tick();
        chk("s2_done_clr", {63'd0, done1}, 64'd0);
        data = 256'h0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        chk("s2b_y_bit0", {63'd0, y1}, 64'd0);
        tick();
        chk("s2b_y_idle", {63'd0, y1}, 64'd1);
        chk("s2b_done", {63'd0, done1}, 64'd1);
        repeat (3) tick();

        // Scenario 3: cnt wrap-around
        cnt = 32'hFFFF_FFFE;
        launch(256'h2, 8'd2, 32'd4, 32'd1);
        wait_drain(20);

        // Scenario 4: start/data changes while busy, then back-to-back frame
        cnt = 32'd10;
        launch(256'hA, 8'd4, 32'd3, 32'd2);
        while (cnt != 32'd15) tick();
        data = 256'h5; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (done0 !== 1'b1 && n < 40);
        chk("s4_done_seen", {63'd0, done0}, 64'd1);
        launch(256'hC, 8'd4, 32'd3, 32'd2);
        chk("s4_b2b_busy", {63'd0, busy0}, 64'd1);
        wait_drain(40);

        // Scenario 5: asynchronous reset mid-frame
        cnt = 32'd10;
        launch(256'hA, 8'd4, 32'd3, 32'd2);
        while (cnt != 32'd16) tick();
        rst = 1'b1;
        #1;
        chk("s5_rst_y", {63'd0, y0}, 64'd0);
        chk("s5_rst_busy", {63'd0, busy0}, 64'd0);
        chk("s5_rst_done", {63'd0, done0}, 64'd0);
        edge_q.delete();
        done_q.delete();
        prev_y = y0;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        while (cnt != 32'd30) tick();
        launch(256'hA, 8'd4, 32'd3, 32'd2);
        wait_drain(30);

        // Scenario 6: 1011 (parity bit appended when enabled)
        cnt = 32'd10;
        launch(256'hB, 8'd4, 32'd3, 32'd2);
        wait_drain(30);

        // nbits=1 frame
        launch(256'h1, 8'd1, 32'd2, 32'd3);
        wait_drain(20);

        // nbits=255 with the unused top bit set
        big = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        big[255] = 1'b1;
        big[254] = 1'b0;
        launch(big, 8'd255, 32'd1, 32'd1);
        wait_drain(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
